// File: rtl/intra_arb_pkg.sv
// rtl/intra_arb_pkg.sv - shared constants, state encoding and beat-count helper for intra_tu_arb
package intra_arb_pkg;

  // TU command packing: {cuPredMode[1:0], isPcm, tuSizeLog2[2:0], yTb[3:0], xTb[3:0], mode[5:0]}
  localparam int CMD_W      = 20;
  localparam int CMD_SZ_LSB = 14;
  localparam int CMD_SZ_W   = 3;
  localparam int CNT_W      = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  // Only 4x4..32x32 are legal; anything else is handled as a single-beat 4x4
  function automatic logic tu_size_ok(input logic [CMD_SZ_W-1:0] sz);
    return (sz >= 3'd2) && (sz <= 3'd5);
  endfunction

  // Residual beats of 16 samples per TU: 1/4/16/64 for 4x4/8x8/16x16/32x32
  function automatic logic [CNT_W-1:0] tu_beats(input logic [CMD_SZ_W-1:0] sz);
    logic [CNT_W-1:0] n;
    case (sz)
      3'd3:    n = 7'd4;
      3'd4:    n = 7'd16;
      3'd5:    n = 7'd64;
      default: n = 7'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/intra_rr_arb.sv
// rtl/intra_rr_arb.sv - combinational 3-way round-robin picker (first request at or after the pointer)
module intra_rr_arb (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt_oh,
  output logic [1:0] o_gnt_id,
  output logic       o_any
);

  logic [2:0] w_idx;
  logic       w_found;

  // Scan the three requesters starting at the pointer, wrapping past Cr back to Y
  always_comb begin
    o_gnt_oh = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < 3; i++) begin
      w_idx = {1'b0, i_ptr} + 3'(i);
      if (w_idx >= 3'd3) w_idx = w_idx - 3'd3;
      if (!w_found && i_req[w_idx[1:0]]) begin
        w_found             = 1'b1;
        o_gnt_oh[w_idx[1:0]] = 1'b1;
        o_gnt_id            = w_idx[1:0];
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/intra_tu_arb.sv
// rtl/intra_tu_arb.sv - round-robin TU scheduler for the shared intra datapath; INTRA_ARB_PERF_EN adds perf counters
module intra_tu_arb
  import intra_arb_pkg::*;
#(
  parameter int bitDepthY = 10,
  parameter int NREQ      = 3
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic [NREQ-1:0]                   req_val,
  output logic [NREQ-1:0]                   req_rdy,
  input  logic [NREQ*CMD_W-1:0]             req_cmd,
  input  logic [NREQ*(bitDepthY+1)*16-1:0]  req_resi,
  input  logic [NREQ-1:0]                   req_resi_val,
  output logic [NREQ-1:0]                   req_resi_rdy,
  output logic                              dp_cmd_val,
  input  logic                              dp_cmd_rdy,
  output logic [CMD_W-1:0]                  dp_cmd,
  output logic [(bitDepthY+1)*16-1:0]       dp_resi,
  output logic                              dp_resi_val,
  input  logic                              dp_resi_rdy,
  output logic [1:0]                        gnt_id,
  output logic                              busy,
  output logic                              tu_done,
`ifdef INTRA_ARB_PERF_EN
  output logic [31:0]                       perf_gnt_y,
  output logic [31:0]                       perf_gnt_cb,
  output logic [31:0]                       perf_gnt_cr,
  output logic [31:0]                       perf_stall,
`endif
  output logic                              err_tusize
);

  localparam int RESI_W = (bitDepthY + 1) * 16;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       r_gnt_id;
  logic [CMD_W-1:0] r_cmd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tu_done;
  logic             r_err;

  logic [CMD_W-1:0]  w_cmd  [NREQ];
  logic [RESI_W-1:0] w_resi [NREQ];
  logic [CMD_W-1:0]  w_sel_cmd;
  logic [2:0]        w_gnt_oh;
  logic [1:0]        w_pick_id;
  logic              w_any;
  logic              w_cmd_fire;
  logic              w_beat_fire;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_cmd[g]  = req_cmd[g*CMD_W +: CMD_W];
    assign w_resi[g] = req_resi[g*RESI_W +: RESI_W];
  end

  intra_rr_arb u_rr (
    .i_req    (req_val),
    .i_ptr    (r_ptr),
    .o_gnt_oh (w_gnt_oh),
    .o_gnt_id (w_pick_id),
    .o_any    (w_any)
  );

  // One-hot AND-OR select of the winning requester's command
  always_comb begin
    w_sel_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_oh[i]) w_sel_cmd = w_sel_cmd | w_cmd[i];
    end
  end

  assign w_cmd_fire  = (r_state == ISSUE) && dp_cmd_rdy;
  assign w_beat_fire = (r_state == DATA) && dp_resi_val && dp_resi_rdy;

  // State register; async reset drops any TU in flight
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state and handshake routing; everything idles at zero outside the owning state
  always_comb begin
    w_state_nxt  = r_state;
    req_rdy      = '0;
    req_resi_rdy = '0;
    dp_cmd_val   = 1'b0;
    dp_cmd       = '0;
    dp_resi      = '0;
    dp_resi_val  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        dp_cmd_val = 1'b1;
        dp_cmd     = r_cmd;
        if (dp_cmd_rdy) begin
          req_rdy[r_gnt_id] = 1'b1;
          w_state_nxt       = DATA;
        end
      end
      DATA: begin
        dp_resi                = w_resi[r_gnt_id];
        dp_resi_val            = req_resi_val[r_gnt_id];
        req_resi_rdy[r_gnt_id] = dp_resi_rdy;
        if (dp_resi_val && dp_resi_rdy && (r_cnt == 7'd1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant latch, beat counter, round-robin pointer, done pulse and sticky size error
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ptr     <= '0;
      r_gnt_id  <= '0;
      r_cmd     <= '0;
      r_cnt     <= '0;
      r_tu_done <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tu_done <= 1'b0;
      if ((r_state == IDLE) && w_any) begin
        r_gnt_id <= w_pick_id;
        r_cmd    <= w_sel_cmd;
        if (!tu_size_ok(w_sel_cmd[CMD_SZ_LSB +: CMD_SZ_W])) r_err <= 1'b1;
      end
      if (w_cmd_fire) begin
        r_cnt <= tu_beats(r_cmd[CMD_SZ_LSB +: CMD_SZ_W]);
        r_ptr <= (r_gnt_id == 2'd2) ? 2'd0 : r_gnt_id + 2'd1;
      end
      if (w_beat_fire) begin
        r_cnt <= r_cnt - 7'd1;
        if (r_cnt == 7'd1) r_tu_done <= 1'b1;
      end
    end
  end

  assign gnt_id     = r_gnt_id;
  assign busy       = (r_state != IDLE);
  assign tu_done    = r_tu_done;
  assign err_tusize = r_err;

`ifdef INTRA_ARB_PERF_EN
  // Grant counts per requester (counted at command accept) and datapath back-pressure cycles
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_gnt_y  <= '0;
      perf_gnt_cb <= '0;
      perf_gnt_cr <= '0;
      perf_stall  <= '0;
    end else begin
      if (w_cmd_fire && (r_gnt_id == 2'd0)) perf_gnt_y  <= perf_gnt_y + 32'd1;
      if (w_cmd_fire && (r_gnt_id == 2'd1)) perf_gnt_cb <= perf_gnt_cb + 32'd1;
      if (w_cmd_fire && (r_gnt_id == 2'd2)) perf_gnt_cr <= perf_gnt_cr + 32'd1;
      if ((r_state == DATA) && dp_resi_val && !dp_resi_rdy) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_intra_tu_arb.sv
// tb/tb_intra_tu_arb.sv - directed self-checking bench for intra_tu_arb
module tb_intra_tu_arb;

  localparam int RW = 176;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [2:0]    req_val;
  logic [2:0]    req_rdy;
  logic [59:0]   req_cmd;
  logic [3*RW-1:0] req_resi;
  logic [2:0]    req_resi_val;
  logic [2:0]    req_resi_rdy;
  logic          dp_cmd_val;
  logic          dp_cmd_rdy;
  logic [19:0]   dp_cmd;
  logic [RW-1:0] dp_resi;
  logic          dp_resi_val;
  logic          dp_resi_rdy;
  logic [1:0]    gnt_id;
  logic          busy;
  logic          tu_done;
  logic          err_tusize;
`ifdef INTRA_ARB_PERF_EN
  logic [31:0]   perf_gnt_y, perf_gnt_cb, perf_gnt_cr, perf_stall;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  intra_tu_arb dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_cmd      (req_cmd),
    .req_resi     (req_resi),
    .req_resi_val (req_resi_val),
    .req_resi_rdy (req_resi_rdy),
    .dp_cmd_val   (dp_cmd_val),
    .dp_cmd_rdy   (dp_cmd_rdy),
    .dp_cmd       (dp_cmd),
    .dp_resi      (dp_resi),
    .dp_resi_val  (dp_resi_val),
    .dp_resi_rdy  (dp_resi_rdy),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .tu_done      (tu_done),
`ifdef INTRA_ARB_PERF_EN
    .perf_gnt_y   (perf_gnt_y),
    .perf_gnt_cb  (perf_gnt_cb),
    .perf_gnt_cr  (perf_gnt_cr),
    .perf_stall   (perf_stall),
`endif
    .err_tusize   (err_tusize)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [2:0] sz, input logic [5:0] mode);
    return {2'b01, 1'b0, sz, 4'h2, 4'h3, mode};
  endfunction

  function automatic logic [RW-1:0] pat(input int n);
    logic [RW-1:0] p;
    for (int j = 0; j < 16; j++) p[j*11 +: 11] = 11'(n * 3 + j);
    return p;
  endfunction

  task automatic set_cmd(input int i, input logic [19:0] c);
    req_cmd[i*20 +: 20] = c;
  endtask

  task automatic set_resi(input int i, input logic [RW-1:0] d);
    req_resi[i*RW +: RW] = d;
  endtask

  logic [19:0] cmds [3];
  int e, acc, mism, dones;

  initial begin
    arst_n = 1'b0; req_val = '0; req_cmd = '0; req_resi = '0; req_resi_val = '0;
    dp_cmd_rdy = 1'b0; dp_resi_rdy = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_cmd_val", dp_cmd_val, 0);
    check("rst_resi_val", dp_resi_val, 0);
    check("rst_tu_done", tu_done, 0);
    check("rst_err", err_tusize, 0);
    check("rst_req_rdy", req_rdy, 0);
    arst_n = 1'b1;

    // Only Y, 8x8: one command handshake, 4 beats, done one cycle after beat 4
    set_cmd(0, mk(3'd3, 6'h11)); req_val = 3'b001; dp_cmd_rdy = 1'b1; dp_resi_rdy = 1'b1;
    #1;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_req_rdy", req_rdy, 0);
    tick();
    check("t1_cmd_val", dp_cmd_val, 1);
    check("t1_cmd", dp_cmd, mk(3'd3, 6'h11));
    check("t1_req_rdy", req_rdy, 3'b001);
    check("t1_gnt", gnt_id, 0);
    req_val = 3'b000; req_resi_val = 3'b001;
    tick();
    for (int k = 0; k < 4; k++) begin
      set_resi(0, pat(k)); #1;
      check("t1_beat_data", dp_resi, pat(k));
      check("t1_beat_rdy", req_resi_rdy, 3'b001);
      check("t1_no_early_done", tu_done, 0);
      tick();
    end
    req_resi_val = 3'b000;
    check("t1_done", tu_done, 1);
    check("t1_idle_after", busy, 0);
    tick();
    check("t1_done_pulse", tu_done, 0);

    // Fresh reset, all three continuously requesting 4x4: order Y, Cb, Cr, Y with an idle cycle between
    arst_n = 1'b0; #1; arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmds[i] = mk(3'd2, 6'(i + 1));
      set_cmd(i, cmds[i]);
      set_resi(i, pat(100 * (i + 1)));
    end
    req_val = 3'b111; req_resi_val = 3'b111; #1;
    for (int k = 0; k < 4; k++) begin
      e = k % 3;
      check("t2_idle", busy, 0);
      tick();
      check("t2_gnt", gnt_id, e);
      check("t2_cmd", dp_cmd, cmds[e]);
      check("t2_req_rdy", req_rdy, 256'(1) << e);
      tick();
      check("t2_data", dp_resi, pat(100 * (e + 1)));
      check("t2_resi_rdy", req_resi_rdy, 256'(1) << e);
      tick();
      check("t2_done", tu_done, 1);
    end

    // 32x32 from Y with dp_resi_rdy toggling: exactly 64 in-order beats, one tu_done
    req_val = 3'b001; req_resi_val = 3'b000; set_cmd(0, mk(3'd5, 6'h20)); #1;
    tick();
    check("t3_cmd", dp_cmd, mk(3'd5, 6'h20));
    req_val = 3'b000;
    tick();
    acc = 0; mism = 0; dones = 0;
    for (int cyc = 0; cyc < 180; cyc++) begin
      dp_resi_rdy  = cyc[0];
      req_resi_val = (acc < 64) ? 3'b111 : 3'b000;
      set_resi(0, pat(1000 + acc));
      #1;
      if (tu_done) dones++;
      if (dp_resi_val && dp_resi_rdy) begin
        if (dp_resi !== pat(1000 + acc)) mism++;
        acc++;
      end
      tick();
    end
    req_resi_val = 3'b000; dp_resi_rdy = 1'b1;
    check("t3_beats", acc, 64);
    check("t3_mism", mism, 0);
    check("t3_dones", dones, 1);
    check("t3_idle", busy, 0);

    // dp_cmd_rdy low 10 cycles: command held stable, req_rdy only on accept, latched despite req changes
    set_cmd(1, mk(3'd2, 6'h15)); req_val = 3'b010; dp_cmd_rdy = 1'b0; #1;
    tick();
    req_val = 3'b000; set_cmd(1, 20'hfffff);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t4_hold_val", dp_cmd_val, 1);
      check("t4_hold_cmd", dp_cmd, mk(3'd2, 6'h15));
      check("t4_hold_rdy", req_rdy, 0);
      tick();
    end
    dp_cmd_rdy = 1'b1; #1;
    check("t4_accept_rdy", req_rdy, 3'b010);
    check("t4_gnt", gnt_id, 1);
    tick();
    req_resi_val = 3'b010; set_resi(1, pat(77)); #1;
    check("t4_data", dp_resi, pat(77));
    tick();
    req_resi_val = 3'b000;
    check("t4_done", tu_done, 1);

    // tuSizeLog2=7: sticky error, one beat consumed
    set_cmd(2, mk(3'd7, 6'h2a)); req_val = 3'b100; #1;
    tick();
    check("t5_err", err_tusize, 1);
    check("t5_gnt", gnt_id, 2);
    req_val = 3'b000;
    tick();
    req_resi_val = 3'b100; #1;
    check("t5_beat_val", dp_resi_val, 1);
    tick();
    req_resi_val = 3'b000;
    check("t5_done_1beat", tu_done, 1);
    check("t5_idle", busy, 0);
    repeat (3) tick();
    check("t5_err_sticky", err_tusize, 1);

    // Reset during beat 10 of 16: immediate idle, no tu_done, next grant to Y
    set_cmd(1, mk(3'd4, 6'h0c)); req_val = 3'b010; #1;
    tick();
    req_val = 3'b000;
    tick();
    req_resi_val = 3'b010; dones = 0;
    for (int i = 0; i < 9; i++) begin
      set_resi(1, pat(i)); #1;
      if (tu_done) dones++;
      tick();
    end
    check("t6_mid_busy", busy, 1);
    check("t6_mid_val", dp_resi_val, 1);
    arst_n = 1'b0; #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_resi_val", dp_resi_val, 0);
    check("t6_rst_err", err_tusize, 0);
    tick();
    if (tu_done) dones++;
    arst_n = 1'b1; req_resi_val = 3'b000;
    for (int i = 0; i < 3; i++) set_cmd(i, mk(3'd2, 6'(i)));
    req_val = 3'b111; #1;
    if (tu_done) dones++;
    tick();
    check("t6_no_done", dones, 0);
    check("t6_next_gnt", gnt_id, 0);
    req_val = 3'b000;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
